// File: rtl/video_stream_meter_if.sv
// Parallel video stream bundle: pixel data, pixel valid, horizontal and
// vertical sync. The source drives all four; the meter only listens.
interface video_stream_meter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] di_i;
    logic                  de_i;
    logic                  hs_i;
    logic                  vs_i;

    modport master (output di_i, de_i, hs_i, vs_i);
    modport slave  (input  di_i, de_i, hs_i, vs_i);
endinterface

// File: rtl/video_stream_meter.sv
// Sink-side meter for the parallel video stream. Measures line length,
// line count, pixel checksum and frame count for each completed frame, and
// raises sticky flags for length mismatches, blank-time pixels and counter
// saturation.
module video_stream_meter #(
    parameter int DATA_WIDTH      = 8,
    parameter int LINE_SIZE_MAX   = 4096,
    parameter int FRAME_LINES_MAX = 4096,
    localparam int PW = $clog2(LINE_SIZE_MAX + 1),
    localparam int LW = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    video_stream_meter_if.slave vid,
    output logic [PW-1:0]       line_size_o,
    output logic [LW-1:0]       frame_lines_o,
    output logic [31:0]         checksum_o,
    output logic [15:0]         frame_cnt_o,
    output logic                frame_done_o,
    output logic                err_len_o,
    output logic                err_blank_o,
    output logic                err_ovf_o
);

    localparam logic [PW-1:0] PIX_MAX  = PW'(LINE_SIZE_MAX);
    localparam logic [LW-1:0] LINE_MAX = LW'(FRAME_LINES_MAX);

    logic            r_hs;
    logic            r_vs;
    logic            r_armed;     // vs_i=0 has been seen since reset
    logic            r_in_frame;  // between an accepted frame start and its end
    logic [PW-1:0]   r_pix_cnt;
    logic [PW-1:0]   r_ref_len;
    logic [LW-1:0]   r_line_cnt;
    logic [31:0]     r_acc;

    logic [DATA_WIDTH-1:0] w_di;
    logic            w_frame_start;
    logic            w_frame_end;
    logic            w_line_end;
    logic            w_accept;
    logic            w_blank;
    logic            w_close;
    logic            w_first_line;
    logic [PW-1:0]   w_pix_base;
    logic [PW-1:0]   w_pix_nx;
    logic [LW-1:0]   w_line_nx;
    logic [PW-1:0]   w_ref_nx;
    logic [31:0]     w_acc_nx;
    logic            w_len_err;
    logic            w_ovf;

    assign w_di = vid.di_i;

    // Edge detection and next-state arithmetic for the line/frame counters.
    always_comb begin
        // A frame that was already running when reset released has no
        // rising vs edge we trust, so it is neither started nor ended.
        w_frame_start = ~r_vs & vid.vs_i & r_armed;
        w_frame_end   = r_vs & ~vid.vs_i & r_in_frame;
        w_line_end    = ~r_hs & vid.hs_i;
        w_accept      = vid.de_i & ~vid.hs_i & vid.vs_i & (r_in_frame | w_frame_start);
        w_blank       = vid.de_i & (vid.hs_i | ~vid.vs_i);

        // An open line is closed by its own hs rise or by vs dropping first.
        w_close      = r_in_frame & (w_line_end | (w_frame_end & ~vid.hs_i))
                       & (r_pix_cnt != '0);
        w_first_line = (r_line_cnt == '0);

        w_pix_base = w_frame_start ? '0 : r_pix_cnt;
        if (w_close)
            w_pix_nx = '0;
        else if (w_accept)
            w_pix_nx = (w_pix_base == PIX_MAX) ? w_pix_base : w_pix_base + 1'b1;
        else
            w_pix_nx = w_pix_base;

        if (w_frame_start)
            w_line_nx = '0;
        else if (w_close)
            w_line_nx = (r_line_cnt == LINE_MAX) ? r_line_cnt : r_line_cnt + 1'b1;
        else
            w_line_nx = r_line_cnt;

        if (w_frame_start)
            w_ref_nx = '0;
        else if (w_close && w_first_line)
            w_ref_nx = r_pix_cnt;
        else
            w_ref_nx = r_ref_len;

        w_acc_nx  = (w_frame_start ? 32'd0 : r_acc) + (w_accept ? 32'(w_di) : 32'd0);
        w_len_err = w_close & ~w_first_line & (r_pix_cnt != r_ref_len);
        w_ovf     = (w_accept & (w_pix_nx == PIX_MAX))
                  | (w_close & (w_line_nx == LINE_MAX));
    end

    // Input edge registers and per-frame measurement state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs       <= 1'b1;
            r_vs       <= 1'b0;
            r_armed    <= 1'b0;
            r_in_frame <= 1'b0;
            r_pix_cnt  <= '0;
            r_ref_len  <= '0;
            r_line_cnt <= '0;
            r_acc      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_hs       <= vid.hs_i;
            r_vs       <= vid.vs_i;
            r_armed    <= r_armed | ~vid.vs_i;
            r_in_frame <= w_frame_start | (r_in_frame & ~w_frame_end);
            r_pix_cnt  <= w_pix_nx;
            r_ref_len  <= w_ref_nx;
            r_line_cnt <= w_line_nx;
            r_acc      <= w_acc_nx;
        end
    end

    // Frame results, frame counter and sticky flags; a new event beats clr_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_size_o   <= '0;
            frame_lines_o <= '0;
            checksum_o    <= '0;
            frame_cnt_o   <= '0;
            frame_done_o  <= 1'b0;
            err_len_o     <= 1'b0;
            err_blank_o   <= 1'b0;
            err_ovf_o     <= 1'b0;
        end else begin
            frame_done_o <= w_frame_end;
            if (w_frame_end) begin
                line_size_o   <= w_ref_nx;
                frame_lines_o <= w_line_nx;
                checksum_o    <= r_acc;
                frame_cnt_o   <= clr_i ? 16'd1 : frame_cnt_o + 16'd1;
            end else if (clr_i) begin
                frame_cnt_o   <= 16'd0;
            end
            err_len_o   <= (err_len_o   & ~clr_i) | w_len_err;
            err_blank_o <= (err_blank_o & ~clr_i) | w_blank;
            err_ovf_o   <= (err_ovf_o   & ~clr_i) | w_ovf;
        end
    end

endmodule

// File: tb/tb_video_stream_meter.sv
// Self-checking bench for video_stream_meter. Frames are described as a list
// of line lengths; the expected frame results are derived from that list.
module tb_video_stream_meter;

    localparam int DW   = 8;
    localparam int LMAX = 16;
    localparam int FMAX = 8;
    localparam int PW   = $clog2(LMAX + 1);
    localparam int LW   = $clog2(FMAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [PW-1:0] line_size;
    logic [LW-1:0] frame_lines;
    logic [31:0]   checksum;
    logic [15:0]   frame_cnt;
    logic          frame_done;
    logic          err_len;
    logic          err_blank;
    logic          err_ovf;

    always #5 clk = ~clk;

    video_stream_meter_if #(.DATA_WIDTH(DW)) vid ();

    video_stream_meter #(
        .DATA_WIDTH      (DW),
        .LINE_SIZE_MAX   (LMAX),
        .FRAME_LINES_MAX (FMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr),
        .vid           (vid),
        .line_size_o   (line_size),
        .frame_lines_o (frame_lines),
        .checksum_o    (checksum),
        .frame_cnt_o   (frame_cnt),
        .frame_done_o  (frame_done),
        .err_len_o     (err_len),
        .err_blank_o   (err_blank),
        .err_ovf_o     (err_ovf)
    );

    typedef struct {
        int          size;
        int          lines;
        logic [31:0] sum;
        int          cnt;
        bit          e_len;
        bit          e_blank;
        bit          e_ovf;
    } frame_exp_t;

    frame_exp_t  exp_q[$];
    frame_exp_t  held;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;

    // Stimulus description of the next frame.
    int          lens[16];
    int          nlines;
    int          close_mode;   // 0: vs after blanking, 1: vs with last hs rise, 2: vs while hs low
    bit          blank_px;
    bit          seq_data;
    int          de_gap;
    int          line_gap;
    int          seq_val;
    logic [31:0] run_sum;
    bit          cum_len, cum_blank, cum_ovf;
    int          exp_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int first, input int nonempty, input bit mis,
                            input bit ovf, input bit clr_edge);
        frame_exp_t e;
        if (clr_edge) begin
            cum_len = 0; cum_blank = 0; cum_ovf = 0; exp_frames = 0;
        end
        cum_len    = cum_len | mis;
        cum_ovf    = cum_ovf | ovf | (nonempty >= FMAX);
        exp_frames = (exp_frames + 1) % 65536;
        e.size     = (first < 0) ? 0 : first;
        e.lines    = (nonempty > FMAX) ? FMAX : nonempty;
        e.sum      = run_sum;
        e.cnt      = exp_frames;
        e.e_len    = cum_len;
        e.e_blank  = cum_blank;
        e.e_ovf    = cum_ovf;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input bit clr_on_close);
        int first    = -1;
        int nonempty = 0;
        bit mis      = 0;
        bit ovf      = 0;
        run_sum = 0;
        vid.vs_i = 1; vid.hs_i = 1; vid.de_i = 0;
        repeat (4) tick();
        for (int l = 0; l < nlines; l++) begin
            bit last;
            last = (l == nlines - 1);
            if (lens[l] > 0) begin
                int s;
                s = (lens[l] >= LMAX) ? LMAX : lens[l];
                nonempty++;
                if (lens[l] >= LMAX) ovf = 1;
                if (first < 0) first = s;
                else if (s != first) mis = 1;
            end
            vid.hs_i = 0;
            tick();
            for (int p = 0; p < lens[l]; p++) begin
                vid.de_i = 1;
                vid.di_i = seq_data ? 8'(seq_val) : 8'($urandom_range(0, 255));
                seq_val++;
                run_sum += 32'(vid.di_i);
                tick();
                vid.de_i = 0;
                repeat (de_gap) tick();
            end
            if (last && close_mode == 1) begin
                vid.hs_i = 1; vid.vs_i = 0;
                tick();
                push_exp(first, nonempty, mis, ovf, 0);
            end else if (last && close_mode == 2) begin
                vid.vs_i = 0;
                tick();
                push_exp(first, nonempty, mis, ovf, 0);
                vid.hs_i = 1;
                tick();
            end else begin
                vid.hs_i = 1;
                for (int g = 0; g < line_gap; g++) begin
                    if (blank_px && g == 1) begin
                        vid.de_i = 1; vid.di_i = 8'hAA; cum_blank = 1;
                    end
                    tick();
                    vid.de_i = 0;
                end
            end
        end
        if (nlines == 0 || close_mode == 0) begin
            if (clr_on_close) clr = 1;
            vid.vs_i = 0;
            tick();
            clr = 0;
            push_exp(first, nonempty, mis, ovf, clr_on_close);
        end
        vid.hs_i = 1;
        repeat (4) tick();
    endtask

    task automatic set_4x3(input bit seq);
        nlines = 3;
        for (int l = 0; l < 3; l++) lens[l] = 4;
        close_mode = 0; blank_px = 0; seq_data = seq; de_gap = 1; line_gap = 35;
        seq_val = 1;
    endtask

    task automatic do_clear();
        clr = 1;
        tick();
        clr = 0;
        cum_len = 0; cum_blank = 0; cum_ovf = 0; exp_frames = 0;
        check("clr_err_len", 32'(err_len), 0);
        check("clr_err_blank", 32'(err_blank), 0);
        check("clr_err_ovf", 32'(err_ovf), 0);
        check("clr_frame_cnt", 32'(frame_cnt), 0);
    endtask

    // Compare process: frame results on every done pulse, hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            held = '{default: 0};
            check("rst_line_size", 32'(line_size), 0);
            check("rst_frame_cnt", 32'(frame_cnt), 0);
            check("rst_done", 32'(frame_done), 0);
        end else if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame_done: got pulse, expected none");
            end else begin
                held = exp_q.pop_front();
                check("frame_line_size", 32'(line_size), 32'(held.size));
                check("frame_lines", 32'(frame_lines), 32'(held.lines));
                check("frame_checksum", checksum, held.sum);
                check("frame_cnt", 32'(frame_cnt), 32'(held.cnt));
                check("frame_err_len", 32'(err_len), 32'(held.e_len));
                check("frame_err_blank", 32'(err_blank), 32'(held.e_blank));
                check("frame_err_ovf", 32'(err_ovf), 32'(held.e_ovf));
            end
        end else begin
            check("hold_line_size", 32'(line_size), 32'(held.size));
            check("hold_lines", 32'(frame_lines), 32'(held.lines));
            check("hold_checksum", checksum, held.sum);
        end
    end

    initial begin
        rst = 1; clr = 0;
        vid.vs_i = 0; vid.hs_i = 1; vid.de_i = 0; vid.di_i = '0;
        cum_len = 0; cum_blank = 0; cum_ovf = 0; exp_frames = 0;
        repeat (3) tick();
        rst = 0;
        repeat (2) tick();
        check("reset_line_size", 32'(line_size), 0);
        check("reset_frame_lines", 32'(frame_lines), 0);
        check("reset_checksum", checksum, 0);
        check("reset_frame_cnt", 32'(frame_cnt), 0);
        check("reset_errors", {29'd0, err_len, err_blank, err_ovf}, 0);

        // Two clean 4x3 frames with pixels 1..12.
        set_4x3(1);
        send_frame(0);
        check("f1_line_size", 32'(line_size), 4);
        check("f1_frame_lines", 32'(frame_lines), 3);
        check("f1_checksum", checksum, 78);
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        check("f1_done_pulses", 32'(n_done), 1);
        check("f1_errors", {29'd0, err_len, err_blank, err_ovf}, 0);
        set_4x3(1);
        send_frame(0);
        check("f2_frame_cnt", 32'(frame_cnt), 2);

        // Second line one pixel longer.
        set_4x3(0);
        lens[1] = 5;
        send_frame(0);
        check("len_err_set", 32'(err_len), 1);
        check("len_line_size", 32'(line_size), 4);
        check("len_frame_lines", 32'(frame_lines), 3);
        tick();
        check("len_err_sticky", 32'(err_len), 1);
        do_clear();

        // Pixel during horizontal blanking must not be summed.
        set_4x3(1);
        blank_px = 1;
        send_frame(0);
        check("blank_err_set", 32'(err_blank), 1);
        check("blank_checksum", checksum, 78);

        // vs falls together with the last hs rise, then with hs still low.
        set_4x3(0);
        close_mode = 1;
        send_frame(0);
        check("close_hs_vs_lines", 32'(frame_lines), 3);
        set_4x3(0);
        close_mode = 2;
        send_frame(0);
        check("close_vs_only_lines", 32'(frame_lines), 3);

        // Pixel and line counter saturation.
        set_4x3(0);
        nlines = 1; lens[0] = 18; de_gap = 0;
        send_frame(0);
        check("ovf_line_size", 32'(line_size), 16);
        check("ovf_err_set", 32'(err_ovf), 1);
        set_4x3(0);
        nlines = 9; line_gap = 3;
        for (int l = 0; l < 9; l++) lens[l] = 2;
        send_frame(0);
        check("ovf_frame_lines", 32'(frame_lines), FMAX);

        // clr_i on the frame-end edge: the new frame still counts.
        set_4x3(0);
        send_frame(1);
        check("clr_close_frame_cnt", 32'(frame_cnt), 1);
        check("clr_close_err_ovf", 32'(err_ovf), 0);

        // Frame without any lines.
        nlines = 0;
        send_frame(0);
        check("empty_line_size", 32'(line_size), 0);
        check("empty_frame_lines", 32'(frame_lines), 0);
        check("empty_checksum", checksum, 0);

        // Reset after the first line; the rest of that frame is not reported.
        set_4x3(1);
        vid.vs_i = 1; vid.hs_i = 1;
        repeat (4) tick();
        vid.hs_i = 0; tick();
        for (int p = 0; p < 4; p++) begin
            vid.de_i = 1; vid.di_i = 8'(p + 1); tick(); vid.de_i = 0; tick();
        end
        vid.hs_i = 1;
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        cum_len = 0; cum_blank = 0; cum_ovf = 0; exp_frames = 0;
        check("midrst_line_size", 32'(line_size), 0);
        check("midrst_frame_lines", 32'(frame_lines), 0);
        check("midrst_checksum", checksum, 0);
        check("midrst_frame_cnt", 32'(frame_cnt), 0);
        for (int l = 0; l < 2; l++) begin
            vid.hs_i = 0; tick();
            for (int p = 0; p < 4; p++) begin
                vid.de_i = 1; vid.di_i = 8'(9 * p + 3); tick(); vid.de_i = 0; tick();
            end
            vid.hs_i = 1;
            repeat (5) tick();
        end
        vid.vs_i = 0;
        repeat (5) tick();
        check("midrst_unreported", 32'(frame_cnt), 0);
        set_4x3(1);
        send_frame(0);
        check("postrst_line_size", 32'(line_size), 4);
        check("postrst_frame_lines", 32'(frame_lines), 3);
        check("postrst_checksum", checksum, 78);
        check("postrst_frame_cnt", 32'(frame_cnt), 1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int base;
            base       = $urandom_range(1, 8);
            nlines     = $urandom_range(0, 9);
            for (int l = 0; l < nlines; l++)
                lens[l] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 18) : base;
            close_mode = $urandom_range(0, 2);
            blank_px   = ($urandom_range(0, 7) == 0);
            seq_data   = 0;
            de_gap     = $urandom_range(0, 2);
            line_gap   = $urandom_range(2, 6);
            send_frame(0);
            if ($urandom_range(0, 5) == 0) do_clear();
        end

        repeat (3) tick();
        check("pending_frames", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
